vga_pos_loader: RTL and testbench

- Upstream feeder for the VGA sprite renderer.
- Once per frame, at the start of vertical blank, it reads the game-position words from data RAM port B.
- Reads are staged in shadow registers, then committed atomically, so the renderer never sees values from two different frames.
- Replaces the ad-hoc combinational loader in the VGA top; outputs drive the obstacle_x / player_y inputs of the sprite generators directly.

---
 rtl/vga_pos_loader.sv | 135 +++++++++++++
 tb/tb_vga_pos_loader.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_pos_loader.sv
// vga_pos_loader
// Once per frame, on the rising edge of the (hcount, vcount) == (TRIG_H, TRIG_V)
// trigger, fetches two position words from data RAM port B, stages them, and
// commits both to the sprite generators on the same edge. This way the renderer
// never mixes values from two different frames.
//
// Ports:
//   sys_clk     in   system clock (only clock)
//   rst_n       in   synchronous active-low reset
//   load_en     in   1 = fetch on each frame trigger, 0 = hold committed values
//   hcount      in   [9:0]  horizontal pixel counter
//   vcount      in   [9:0]  vertical line counter
//   ram_q_b     in   [15:0] RAM port-B read data
//   ram_addr_b  out  [15:0] RAM port-B address (registered)
//   obstacle_x  out  [15:0] committed obstacle x position
//   player_y    out  [15:0] committed player y position
//   frame_tick  out  one-cycle pulse in the first cycle new values are visible
//   load_busy   out  high while the loader is not IDLE
//   frame_count out  [15:0] number of commits since reset (wraps)
module vga_pos_loader #(
  parameter logic [15:0] POS_BASE   = 16'h0100,
  parameter int          RD_LATENCY = 1,
  parameter logic [9:0]  TRIG_H     = 10'd0,
  parameter logic [9:0]  TRIG_V     = 10'd480,
  parameter logic [15:0] RST_X      = 16'd400,
  parameter logic [15:0] RST_Y      = 16'd200
) (
  input  logic        sys_clk,
  input  logic        rst_n,
  input  logic        load_en,
  input  logic [9:0]  hcount,
  input  logic [9:0]  vcount,
  input  logic [15:0] ram_q_b,
  output logic [15:0] ram_addr_b,
  output logic [15:0] obstacle_x,
  output logic [15:0] player_y,
  output logic        frame_tick,
  output logic        load_busy,
  output logic [15:0] frame_count
);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    CAPTURE,
    COMMIT
  } state_t;

  localparam logic [1:0] LAT = 2'(RD_LATENCY);

  state_t      state;
  logic        trig;
  logic        trig_d;
  logic        trig_edge;
  logic        idx;        // word being fetched: 0 = obstacle_x, 1 = player_y
  logic [1:0]  lat_cnt;
  logic [15:0] stage_x;
  logic [15:0] stage_y;

  // The pixel counters advance at half the system clock rate, so the trigger
  // level lasts at least two cycles; only its rising edge starts a load.
  assign trig      = (hcount == TRIG_H) && (vcount == TRIG_V);
  assign trig_edge = trig && !trig_d;

  // NOTE: all state, including the two staging words, is cleared by reset and
  // updated with non-blocking assignments in one clocked block, so every output
  // is a flop and a mid-load reset throws away partially staged data.
  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      trig_d      <= 1'b0;
      idx         <= 1'b0;
      lat_cnt     <= 2'd0;
      stage_x     <= 16'd0;
      stage_y     <= 16'd0;
      ram_addr_b  <= POS_BASE;
      obstacle_x  <= RST_X;
      player_y    <= RST_Y;
      frame_tick  <= 1'b0;
      load_busy   <= 1'b0;
      frame_count <= 16'd0;
    end else begin
      trig_d     <= trig;
      frame_tick <= 1'b0;

      case (state)
        IDLE: begin
          // load_en is only consulted here; dropping it mid-load has no effect.
          if (trig_edge && load_en) begin
            idx       <= 1'b0;
            load_busy <= 1'b1;
            state     <= ISSUE;
          end
        end

        ISSUE: begin
          ram_addr_b <= POS_BASE + 16'(idx);
          lat_cnt    <= LAT;
          state      <= WAIT;
        end

        // Stays here exactly RD_LATENCY cycles so CAPTURE samples the data
        // belonging to the address just issued.
        WAIT: begin
          lat_cnt <= lat_cnt - 2'd1;
          if (lat_cnt == 2'd1) state <= CAPTURE;
        end

        CAPTURE: begin
          if (idx) begin
            stage_y <= ram_q_b;
            state   <= COMMIT;
          end else begin
            stage_x <= ram_q_b;
            idx     <= 1'b1;
            state   <= ISSUE;
          end
        end

        COMMIT: begin
          obstacle_x  <= stage_x;
          player_y    <= stage_y;
          frame_tick  <= 1'b1;
          frame_count <= frame_count + 16'd1;
          load_busy   <= 1'b0;
          state       <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vga_pos_loader.sv
// tb_vga_pos_loader
// Drives two loaders side by side (RD_LATENCY 1 and 3), each with its own RAM
// read pipeline of matching latency over a shared two-word memory. Expected
// commits (data, count, due cycle, address change cycles) are queued when a
// trigger is driven and retired when the due cycle arrives; every cycle both
// instances are compared against the scoreboard.
module tb_vga_pos_loader;

  localparam logic [15:0] POS_BASE = 16'h0100;

  typedef struct {
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] cnt;
    int          start;
    int          due;
    int          a1;
    int          a2;
  } exp_t;

  logic        sys_clk;
  logic        rst_n;
  logic        load_en;
  logic [9:0]  hcount;
  logic [9:0]  vcount;

  logic [15:0] addr1, q1, x1, y1, cnt1;
  logic        tick1, busy1;
  logic [15:0] addr3, q3, x3, y3, cnt3;
  logic        tick3, busy3;
  logic [15:0] p0, p1;

  logic [15:0] mem0, mem1;

  exp_t        sb0[$];
  exp_t        sb1[$];
  logic [15:0] cur_x[2], cur_y[2], cur_cnt[2], cur_addr[2];
  int          cyc;
  int          n_checks;
  int          n_fail;

  vga_pos_loader #(.RD_LATENCY(1)) u_dut1 (
    .sys_clk(sys_clk), .rst_n(rst_n), .load_en(load_en),
    .hcount(hcount), .vcount(vcount), .ram_q_b(q1),
    .ram_addr_b(addr1), .obstacle_x(x1), .player_y(y1),
    .frame_tick(tick1), .load_busy(busy1), .frame_count(cnt1)
  );

  vga_pos_loader #(.RD_LATENCY(3)) u_dut3 (
    .sys_clk(sys_clk), .rst_n(rst_n), .load_en(load_en),
    .hcount(hcount), .vcount(vcount), .ram_q_b(q3),
    .ram_addr_b(addr3), .obstacle_x(x3), .player_y(y3),
    .frame_tick(tick3), .load_busy(busy3), .frame_count(cnt3)
  );

  initial sys_clk = 1'b0;
  always #10 sys_clk = ~sys_clk;

  function automatic logic [15:0] rd(input logic [15:0] a);
    if (a == POS_BASE)         return mem0;
    if (a == POS_BASE + 16'd1) return mem1;
    return 16'hDEAD ^ a;
  endfunction

  // RAM models: one-cycle and three-cycle read latency.
  always_ff @(posedge sys_clk) begin
    q1 <= rd(addr1);
    p0 <= rd(addr3);
    p1 <= p0;
    q3 <= p1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic mon(input int d, input logic tick, input logic [15:0] addr,
                     input logic [15:0] x, input logic [15:0] y,
                     input logic [15:0] cnt, input logic busy);
    exp_t e;
    bit   have;
    bit   due_now;
    bit   busy_exp;
    have = 1'b0;
    if (d == 0) begin
      if (sb0.size() > 0) begin e = sb0[0]; have = 1'b1; end
    end else begin
      if (sb1.size() > 0) begin e = sb1[0]; have = 1'b1; end
    end
    due_now  = have && (cyc == e.due);
    busy_exp = have && (cyc > e.start) && (cyc < e.due);
    if (have && cyc == e.a1) cur_addr[d] = POS_BASE;
    if (have && cyc == e.a2) cur_addr[d] = POS_BASE + 16'd1;
    if (due_now) begin
      cur_x[d]   = e.x;
      cur_y[d]   = e.y;
      cur_cnt[d] = e.cnt;
      if (d == 0) void'(sb0.pop_front());
      else        void'(sb1.pop_front());
    end
    check($sformatf("d%0d.tick@%0d", d, cyc), 32'(tick), 32'(due_now));
    check($sformatf("d%0d.busy@%0d", d, cyc), 32'(busy), 32'(busy_exp));
    check($sformatf("d%0d.addr@%0d", d, cyc), 32'(addr), 32'(cur_addr[d]));
    check($sformatf("d%0d.x@%0d", d, cyc), 32'(x), 32'(cur_x[d]));
    check($sformatf("d%0d.y@%0d", d, cyc), 32'(y), 32'(cur_y[d]));
    check($sformatf("d%0d.cnt@%0d", d, cyc), 32'(cnt), 32'(cur_cnt[d]));
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge sys_clk);
      #1;
      cyc++;
      mon(0, tick1, addr1, x1, y1, cnt1, busy1);
      mon(1, tick3, addr3, x3, y3, cnt3, busy3);
    end
  endtask

  // Drives the trigger point; cycle 0 is the cycle right after this call.
  task automatic trigger(input bit expect_load);
    exp_t e;
    hcount = 10'd0;
    vcount = 10'd480;
    if (expect_load) begin
      e.x = mem0;
      e.y = mem1;
      e.start = cyc;
      e.a1 = cyc + 2;
      e.cnt = cur_cnt[0] + 16'd1;
      e.due = cyc + 8;
      e.a2 = cyc + 5;
      sb0.push_back(e);
      e.cnt = cur_cnt[1] + 16'd1;
      e.due = cyc + 12;
      e.a2 = cyc + 7;
      sb1.push_back(e);
    end
  endtask

  task automatic untrig();
    hcount = 10'd1;
    vcount = 10'd480;
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    sb0.delete();
    sb1.delete();
    for (int d = 0; d < 2; d++) begin
      cur_x[d]    = 16'd400;
      cur_y[d]    = 16'd200;
      cur_cnt[d]  = 16'd0;
      cur_addr[d] = POS_BASE;
    end
    step(n);
    rst_n = 1'b1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    cyc      = 0;
    rst_n    = 1'b0;
    load_en  = 1'b1;
    hcount   = 10'd5;
    vcount   = 10'd100;
    mem0     = 16'h0123;
    mem1     = 16'h0050;

    // Reset held three cycles, released with the trigger false.
    do_reset(3);
    step(1);
    check("rst.addr1", 32'(addr1), 32'h0100);
    check("rst.addr3", 32'(addr3), 32'h0100);
    check("rst.x", 32'(x1), 32'd400);
    check("rst.y", 32'(y1), 32'd200);
    check("rst.tick", 32'(tick1), 32'd0);
    check("rst.cnt", 32'(cnt1), 32'd0);

    // Basic frame.
    trigger(1'b1);
    step(2);
    untrig();
    step(14);
    check("basic.x1", 32'(x1), 32'h0123);
    check("basic.y1", 32'(y1), 32'h0050);
    check("basic.x3", 32'(x3), 32'h0123);
    check("basic.y3", 32'(y3), 32'h0050);
    check("basic.cnt", 32'(cnt1), 32'd1);

    // Trigger held four cycles, then re-raised while both loaders are busy.
    mem0 = 16'h1111;
    mem1 = 16'h2222;
    trigger(1'b1);
    step(4);
    untrig();
    step(1);
    trigger(1'b0);
    step(2);
    untrig();
    step(14);
    check("hold.cnt1", 32'(cnt1), 32'd2);
    check("hold.cnt3", 32'(cnt3), 32'd2);

    // Fresh data for the slow RAM: stale capture would show old/other words.
    mem0 = 16'hA5A5;
    mem1 = 16'h5A5A;
    trigger(1'b1);
    step(2);
    untrig();
    step(14);
    check("lat3.x", 32'(x3), 32'hA5A5);
    check("lat3.y", 32'(y3), 32'h5A5A);

    // load_en low at the trigger: nothing happens.
    mem0 = 16'hBEEF;
    mem1 = 16'hCAFE;
    load_en = 1'b0;
    trigger(1'b0);
    step(2);
    untrig();
    step(14);
    check("noload.x", 32'(x1), 32'hA5A5);

    // load_en dropped the cycle after the edge: load still commits.
    load_en = 1'b1;
    mem0 = 16'h0F0F;
    mem1 = 16'hF0F0;
    trigger(1'b1);
    step(1);
    load_en = 1'b0;
    step(1);
    untrig();
    step(14);
    load_en = 1'b1;
    check("endrop.x", 32'(x1), 32'h0F0F);
    check("endrop.y", 32'(y1), 32'hF0F0);

    // Reset in cycle 5 of a load: no commit, reset values return.
    mem0 = 16'h7777;
    mem1 = 16'h8888;
    trigger(1'b1);
    step(2);
    untrig();
    step(3);
    do_reset(1);
    step(14);
    check("midrst.x", 32'(x1), 32'd400);
    check("midrst.y3", 32'(y3), 32'd200);

    // Next trigger after the reset loads normally.
    mem0 = 16'h1234;
    mem1 = 16'h4321;
    trigger(1'b1);
    step(2);
    untrig();
    step(14);
    check("after.x", 32'(x1), 32'h1234);
    check("after.cnt", 32'(cnt1), 32'd1);

    // frame_count wrap from 0xFFFF.
    force u_dut1.frame_count = 16'hFFFF;
    force u_dut3.frame_count = 16'hFFFF;
    #1;
    release u_dut1.frame_count;
    release u_dut3.frame_count;
    cur_cnt[0] = 16'hFFFF;
    cur_cnt[1] = 16'hFFFF;
    step(1);
    mem0 = 16'h0001;
    mem1 = 16'h0002;
    trigger(1'b1);
    step(2);
    untrig();
    step(14);
    check("wrap.cnt1", 32'(cnt1), 32'd0);
    check("wrap.cnt3", 32'(cnt3), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
